// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and data width, reused by the transmitter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    // Bit value that makes the total count of ones (data + parity) even.
    function automatic logic even_parity_bit(input uart_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_checked.sv
// UART receiver (8N1) with running byte sum and framing-error reporting.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a synchronized falling edge
// ST_START  | confirming the start bit at its mid sample
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | checking the even-parity bit (parity build only)
// ST_STOP   | sampling the stop bit; publish byte or flag framing error
// ST_BREAK  | waiting for the line to return high after an error
module uart_rx_checked
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_serial,
    output logic [UART_DATA_W-1:0] o_data,
    output logic                   o_valid,
    output logic [31:0]            o_sum,
    output logic                   o_idle,
    output logic                   o_frame_err
);

    localparam logic [15:0] MID_CNT  = 16'((cycles_per_bit - 1) / 2);
    localparam logic [15:0] LAST_CNT = 16'(cycles_per_bit - 1);

    uart_state_t state;
    logic        line_s;
    logic        line_d;
    logic [1:0]  settle;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    uart_byte_t  shreg;
    logic        mid;
    logic        armed;
    logic        fall;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_serial),
        .q     (line_s)
    );

    // Edges are ignored until the synchronizer and line_d hold real line values,
    // so a line already low at reset release is not mistaken for a start bit.
    assign armed = (settle == 2'd3);
    assign fall  = armed && line_d && !line_s;
    assign mid   = (cnt == MID_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            line_d      <= 1'b1;
            settle      <= 2'd0;
            cnt         <= 16'd0;
            bit_idx     <= 3'd0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sum       <= 32'd0;
            o_idle      <= 1'b1;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            line_d      <= line_s;
            if (!armed) begin
                settle <= 2'(settle + 2'd1);
            end

            if (state == ST_IDLE || state == ST_BREAK || cnt == LAST_CNT) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state   <= ST_START;
                        bit_idx <= 3'd0;
                        o_idle  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (mid) begin
                        if (line_s) begin
                            state  <= ST_IDLE;
                            o_idle <= 1'b1;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shreg   <= {line_s, shreg[UART_DATA_W-1:1]};
                        bit_idx <= 3'(bit_idx + 3'd1);
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        if (line_s != even_parity_bit(shreg)) begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end else begin
                            state <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (mid) begin
                        if (line_s) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                            o_sum   <= o_sum + {24'd0, shreg};
                            state   <= ST_IDLE;
                            o_idle  <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (line_s) begin
                        state  <= ST_IDLE;
                        o_idle <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_checked.sv
// Self-checking bench for uart_rx_checked: two instances (3 and 16 cycles per bit)
// checked against a frame-level reference model of expected bytes, sums and errors.
module tb_uart_rx_checked;

    localparam int CPB_A = 3;
    localparam int CPB_B = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PARITY_EN  = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PARITY_EN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_a = 1'b1;
    logic        ser_b = 1'b1;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b;
    logic [31:0] sum_a, sum_b;
    logic        idle_a, idle_b;
    logic        err_a, err_b;

    uart_rx_checked #(.cycles_per_bit(CPB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_serial(ser_a), .o_data(data_a), .o_valid(valid_a),
        .o_sum(sum_a), .o_idle(idle_a), .o_frame_err(err_a)
    );

    uart_rx_checked #(.cycles_per_bit(CPB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_serial(ser_b), .o_data(data_b), .o_valid(valid_b),
        .o_sum(sum_b), .o_idle(idle_b), .o_frame_err(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Observations collected from the outputs (no checking here).
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         vcyc_b[$];
    int         nerr_a = 0, nerr_b = 0, nboth = 0, idle_low_a = 0;

    always @(negedge clk) begin
        if (valid_a) got_a.push_back(data_a);
        if (valid_b) begin
            got_b.push_back(data_b);
            vcyc_b.push_back(cyc);
        end
        if (err_a) nerr_a++;
        if (err_b) nerr_b++;
        if ((valid_a && err_a) || (valid_b && err_b)) nboth++;
        if (!idle_a) idle_low_a++;
    end

    // Reference model state.
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [31:0] msum_a = 32'd0, msum_b = 32'd0;
    int          merr_a = 0, merr_b = 0;
    int          start_b[$];

    task automatic send_frame(input bit sel_b, input logic [7:0] b, input bit stop_ok, input bit par_ok);
        int cpb;
        bit bad;
        logic [FRAME_BITS-1:0] bits;
        cpb = sel_b ? CPB_B : CPB_A;
`ifdef UART_RX_PARITY_EN
        bits = {stop_ok, (^b) ^ ~par_ok, b, 1'b0};
`else
        bits = {stop_ok, b, 1'b0};
`endif
        bad = !stop_ok || (PARITY_EN && !par_ok);
        if (sel_b) begin
            start_b.push_back(cyc);
            if (bad) merr_b++;
            else begin exp_b.push_back(b); msum_b += {24'd0, b}; end
        end else begin
            if (bad) merr_a++;
            else begin exp_a.push_back(b); msum_a += {24'd0, b}; end
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (sel_b) ser_b = bits[i];
            else ser_a = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        msum_a = 32'd0;
        msum_b = 32'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL reset_data_a: got %h want 00", data_a); end
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
        tests++; if (sum_a !== 32'd0) begin fails++; $display("FAIL reset_sum_a: got %h want 0", sum_a); end
        tests++; if (idle_a !== 1'b1) begin fails++; $display("FAIL reset_idle_a: got %b want 1", idle_a); end
        tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err_a: got %b want 0", err_a); end
        tests++; if (sum_b !== 32'd0) begin fails++; $display("FAIL reset_sum_b: got %h want 0", sum_b); end
        tests++; if (idle_b !== 1'b1) begin fails++; $display("FAIL reset_idle_b: got %b want 1", idle_b); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (idle_a !== 1'b1) begin fails++; $display("FAIL post_reset_idle_a: got %b want 1", idle_a); end
        tests++; if (got_a.size() !== 0) begin fails++; $display("FAIL post_reset_valid_a: got %0d pulses want 0", got_a.size()); end
    endtask

    task automatic test_hello();
        logic [7:0] msg [5];
        int v0, e0;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        v0 = got_a.size();
        e0 = nerr_a;
        for (int i = 0; i < 5; i++) send_frame(1'b0, msg[i], 1'b1, 1'b1);
        repeat (3 * CPB_A) @(negedge clk);
        tests++; if (got_a.size() - v0 !== 5) begin fails++; $display("FAIL hello_count: got %0d want 5", got_a.size() - v0); end
        for (int i = 0; i < 5; i++) begin
            if (v0 + i < got_a.size()) begin
                tests++; if (got_a[v0+i] !== msg[i]) begin fails++; $display("FAIL hello_byte%0d: got %h want %h", i, got_a[v0+i], msg[i]); end
            end
        end
        tests++; if (sum_a !== 32'h000001F4) begin fails++; $display("FAIL hello_sum: got %h want 000001f4", sum_a); end
        tests++; if (nerr_a !== e0) begin fails++; $display("FAIL hello_err: got %0d errors want 0", nerr_a - e0); end
    endtask

    task automatic test_glitch();
        int v0, e0, il0;
        v0 = got_a.size();
        e0 = nerr_a;
        il0 = idle_low_a;
        ser_a = 1'b0;
        @(negedge clk);
        ser_a = 1'b1;
        repeat (4 * CPB_A) @(negedge clk);
        tests++; if ((idle_low_a > il0) !== 1'b1) begin fails++; $display("FAIL glitch_start_seen: got %0d busy cycles want >0", idle_low_a - il0); end
        tests++; if (idle_a !== 1'b1) begin fails++; $display("FAIL glitch_idle: got %b want 1", idle_a); end
        tests++; if (got_a.size() !== v0) begin fails++; $display("FAIL glitch_valid: got %0d pulses want 0", got_a.size() - v0); end
        tests++; if (nerr_a !== e0) begin fails++; $display("FAIL glitch_err: got %0d errors want 0", nerr_a - e0); end
        tests++; if (sum_a !== msum_a) begin fails++; $display("FAIL glitch_sum: got %h want %h", sum_a, msum_a); end
    endtask

    task automatic test_break();
        int v0, e0;
        do_reset();
        v0 = got_a.size();
        e0 = nerr_a;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        repeat (20 * CPB_A) @(negedge clk);
        ser_a = 1'b1;
        repeat (2 * CPB_A) @(negedge clk);
        send_frame(1'b0, 8'h01, 1'b1, 1'b1);
        repeat (3 * CPB_A) @(negedge clk);
        tests++; if (nerr_a - e0 !== 1) begin fails++; $display("FAIL break_err_count: got %0d want 1", nerr_a - e0); end
        tests++; if (got_a.size() - v0 !== 1) begin fails++; $display("FAIL break_valid_count: got %0d want 1", got_a.size() - v0); end
        tests++; if (data_a !== 8'h01) begin fails++; $display("FAIL break_data: got %h want 01", data_a); end
        tests++; if (sum_a !== 32'h00000001) begin fails++; $display("FAIL break_sum: got %h want 00000001", sum_a); end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        logic [7:0] b;
        b = 8'h55;
        ser_a = 1'b0;
        repeat (CPB_A) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ser_a = b[i];
            repeat (CPB_A) @(negedge clk);
        end
        ser_a = b[4];
        @(negedge clk);
        tests++; if (idle_a !== 1'b0) begin fails++; $display("FAIL midframe_busy: got idle %b want 0", idle_a); end
        rst_n = 1'b0;
        #1;
        tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL midframe_rst_data: got %h want 00", data_a); end
        tests++; if (sum_a !== 32'd0) begin fails++; $display("FAIL midframe_rst_sum: got %h want 0", sum_a); end
        tests++; if (idle_a !== 1'b1) begin fails++; $display("FAIL midframe_rst_idle: got %b want 1", idle_a); end
        tests++; if (valid_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL midframe_rst_pulses: got valid %b err %b want 0 0", valid_a, err_a); end
        repeat (2) @(negedge clk);
        ser_a = 1'b1;
        rst_n = 1'b1;
        msum_a = 32'd0;
        msum_b = 32'd0;
        repeat (4 * CPB_A) @(negedge clk);
        v0 = got_a.size();
        e0 = nerr_a;
        send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
        repeat (3 * CPB_A) @(negedge clk);
        tests++; if (got_a.size() - v0 !== 1) begin fails++; $display("FAIL midframe_valid_count: got %0d want 1", got_a.size() - v0); end
        tests++; if (data_a !== 8'h3C) begin fails++; $display("FAIL midframe_data: got %h want 3c", data_a); end
        tests++; if (sum_a !== 32'h0000003C) begin fails++; $display("FAIL midframe_sum: got %h want 0000003c", sum_a); end
        tests++; if (nerr_a !== e0) begin fails++; $display("FAIL midframe_err: got %0d errors want 0", nerr_a - e0); end
    endtask

    task automatic test_random();
        int v0, x0, me0, e0, kind;
        logic [7:0] b;
        v0 = got_a.size();
        x0 = exp_a.size();
        me0 = merr_a;
        e0 = nerr_a;
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                send_frame(1'b0, b, 1'b0, 1'b1);
                repeat (CPB_A * $urandom_range(1, 6)) @(negedge clk);
                ser_a = 1'b1;
                repeat (2 * CPB_A) @(negedge clk);
            end else if (kind == 1 && PARITY_EN) begin
                send_frame(1'b0, b, 1'b1, 1'b0);
            end else begin
                send_frame(1'b0, b, 1'b1, 1'b1);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        repeat (3 * CPB_A) @(negedge clk);
        tests++; if (got_a.size() - v0 !== exp_a.size() - x0) begin fails++; $display("FAIL random_count: got %0d want %0d", got_a.size() - v0, exp_a.size() - x0); end
        for (int i = 0; i < exp_a.size() - x0; i++) begin
            if (v0 + i < got_a.size()) begin
                tests++; if (got_a[v0+i] !== exp_a[x0+i]) begin fails++; $display("FAIL random_byte%0d: got %h want %h", i, got_a[v0+i], exp_a[x0+i]); end
            end
        end
        tests++; if (sum_a !== msum_a) begin fails++; $display("FAIL random_sum: got %h want %h", sum_a, msum_a); end
        tests++; if (nerr_a - e0 !== merr_a - me0) begin fails++; $display("FAIL random_err: got %0d want %0d", nerr_a - e0, merr_a - me0); end
    endtask

    task automatic test_back_to_back();
        int v0, s0;
        int lat;
        lat = 4 + (CPB_B - 1) / 2 + (FRAME_BITS - 1) * CPB_B;
        v0 = got_b.size();
        s0 = start_b.size();
        for (int n = 0; n < 256; n++) begin
            send_frame(1'b1, 8'hFF, 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (3 * CPB_B) @(negedge clk);
        tests++; if (got_b.size() - v0 !== 256) begin fails++; $display("FAIL b2b_count: got %0d want 256", got_b.size() - v0); end
        tests++; if (sum_b !== 32'h0000FF00) begin fails++; $display("FAIL b2b_sum: got %h want 0000ff00", sum_b); end
        tests++; if (sum_b !== msum_b) begin fails++; $display("FAIL b2b_sum_model: got %h want %h", sum_b, msum_b); end
        for (int i = 0; i < 256; i++) begin
            if (v0 + i < got_b.size()) begin
                tests++; if (got_b[v0+i] !== 8'hFF) begin fails++; $display("FAIL b2b_byte%0d: got %h want ff", i, got_b[v0+i]); end
                tests++; if (vcyc_b[v0+i] !== start_b[s0+i] + lat) begin fails++; $display("FAIL b2b_latency%0d: got cycle %0d want %0d", i, vcyc_b[v0+i], start_b[s0+i] + lat); end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, e0;
        logic [31:0] s0;
        v0 = got_a.size();
        e0 = nerr_a;
        s0 = sum_a;
        send_frame(1'b0, 8'h07, 1'b1, 1'b1);
        repeat (2 * CPB_A) @(negedge clk);
        tests++; if (got_a.size() - v0 !== 1) begin fails++; $display("FAIL parity_good_valid: got %0d want 1", got_a.size() - v0); end
        tests++; if (data_a !== 8'h07) begin fails++; $display("FAIL parity_good_data: got %h want 07", data_a); end
        send_frame(1'b0, 8'h07, 1'b1, 1'b0);
        repeat (2 * CPB_A) @(negedge clk);
        tests++; if (nerr_a - e0 !== 1) begin fails++; $display("FAIL parity_bad_err: got %0d want 1", nerr_a - e0); end
        tests++; if (got_a.size() - v0 !== 1) begin fails++; $display("FAIL parity_bad_valid: got %0d want 1", got_a.size() - v0); end
        tests++; if (sum_a !== s0 + 32'd7) begin fails++; $display("FAIL parity_sum: got %h want %h", sum_a, s0 + 32'd7); end
    endtask
`endif

    task automatic test_exclusive();
        tests++; if (nboth !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", nboth); end
        tests++; if (nerr_a !== merr_a) begin fails++; $display("FAIL total_err_a: got %0d want %0d", nerr_a, merr_a); end
        tests++; if (nerr_b !== merr_b) begin fails++; $display("FAIL total_err_b: got %0d want %0d", nerr_b, merr_b); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hello();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_random();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_checked.md
UART_RX_CHECKED -- requirements
Module: uart_rx_checked

Interface
REQ-001 Parameter cycles_per_bit, default 3, clock cycles per serial bit, legal range 3..65535.
REQ-002 Port clk  input  1  sole clock; all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port i_serial  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with parity feature).
REQ-005 Port o_data  output  8  last good received byte, held until next good byte.
REQ-006 Port o_valid  output  1  one-cycle pulse per good byte.
REQ-007 Port o_sum  output  32  running sum of good bytes.
REQ-008 Port o_idle  output  1  high while the FSM is in IDLE.
REQ-009 Port o_frame_err  output  1  one-cycle pulse on bad stop bit (or bad parity when enabled).

Function
REQ-010 i_serial SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (feature only), STOP, BREAK.
REQ-012 IDLE -> START on a synchronized high-to-low transition; the bit counter loads 0.
REQ-013 Mid-bit sample point SHALL be counter == (cycles_per_bit-1)/2 within each bit period; counter wraps at cycles_per_bit-1.
REQ-014 START: a high line at the mid sample is a false start; return to IDLE, no output pulse.
REQ-015 DATA: sample 8 bits LSB first, one per bit period, into a shift register; a 3-bit index selects DATA exit.
REQ-016 STOP high at mid sample: o_data <= byte, o_valid pulses the next cycle, o_sum <= o_sum + byte (mod 2^32), then IDLE.
REQ-017 STOP low at mid sample: o_frame_err pulses, o_data/o_sum unchanged, FSM enters BREAK.
REQ-018 BREAK: remain until the synchronized line is high, then IDLE; a held-low line never yields extra bytes or errors.
REQ-019 o_valid and o_frame_err SHALL never be high in the same cycle.
REQ-020 Latency: o_valid rises exactly 1 cycle after the stop-bit mid sample.
REQ-021 A falling edge during STOP's second half is ignored; detection only occurs in IDLE.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, o_data 0, o_valid 0, o_sum 0, o_idle 1, o_frame_err 0, synchronizer flops 1, counters 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse; the post-reset line low is treated as a new start only after a high-to-low transition.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: a PARITY state follows DATA, expects even parity over the 8 data bits; mismatch -> o_frame_err pulse, BREAK-style wait for line high, no o_valid.
REQ-025 Macro UART_RX_PARITY_EN undefined: DATA goes directly to STOP; 10-bit frames only.

Structure
REQ-026 The FSM state enum and the 8-bit data width constant SHALL live in shared package uart_pkg, reused by the transmitter.
REQ-027 The synchronizer SHALL be sub-module uart_sync2 (1-bit, reset value 1, async active-low reset).

Verification
REQ-028 cycles_per_bit=3, send 0x48,0x65,0x6C,0x6C,0x6F back-to-back 8N1 -> five o_valid pulses, o_data in that order, final o_sum = 0x000001F4, o_frame_err never high.
REQ-029 Low glitch of 1 bit period/2 (1 cycle) on idle line -> FSM returns to IDLE, no o_valid, no o_frame_err, o_sum unchanged.
REQ-030 Send 0xA5 with stop bit low, then line held low 20 bit periods, then high, then 0x01 -> exactly one o_frame_err pulse, one o_valid with o_data 0x01, o_sum = 0x00000001.
REQ-031 Assert rst_n low during bit 4 of 0x55 -> all outputs at reset values immediately; next clean 0x3C yields o_data 0x3C, o_sum 0x0000003C.
REQ-032 cycles_per_bit=16, send 256 bytes 0xFF -> o_sum = 0x0000FF00; check o_valid rises 1 cycle after each stop mid sample.
REQ-033 UART_RX_PARITY_EN defined: 0x07 with parity 1 -> o_valid; 0x07 with parity 0 -> o_frame_err, o_sum unchanged.
